ooo_mem_responder: RTL and testbench
====================================

Name: ooo_mem_responder

Overview:
- Single-clock memory responder for the core's instruction and data memory ports; it is the responder end of the imem/dmem request/response protocol.
- Backs both ports with one shared word-wide array, arbitrates between the two ports and returns a one-cycle resp after a fixed, parameterised latency.
- Used as the standalone memory behind the ooo core in block-level and core-level benches, and as the contract model for the future cache front end.

Parameters:
- DEPTH_LOG2, 10, log2 of array depth in 32-bit words. Word index = addr[DEPTH_LOG2+1:2]; higher address bits are ignored, so addresses alias.
- LATENCY, 2, cycles from request acceptance to resp. Legal range 1..15.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- imem_addr  in  32  instruction request address
- imem_rmask  in  4  nonzero = read request pending
- imem_rdata  out  32  read data
- imem_resp  out  1  one-cycle response pulse
- dmem_addr  in  32  data request address
- dmem_rmask  in  4  read byte mask
- dmem_wmask  in  4  write byte mask
- dmem_wdata  in  32  write data
- dmem_rdata  out  32  read data
- dmem_resp  out  1  one-cycle response pulse
- load_en  in  1  bench preload write strobe
- load_addr  in  DEPTH_LOG2  preload word index
- load_data  in  32  preload word

Behaviour:
- Reset: one clock, synchronous, active-high. State=IDLE; imem_resp=0, dmem_resp=0, imem_rdata=0, dmem_rdata=0; grant pointer gives imem priority on the first conflict. Array contents are not reset.
- Request handshake:
  - imem is pending when imem_rmask!=0. dmem is pending when (dmem_rmask|dmem_wmask)!=0.
  - The requester holds addr, masks and wdata stable until it sees resp.
  - The requester drops or changes its request in the cycle after resp.
- FSM:
  - IDLE: if any port is pending, accept one port at the clock edge. Latch port id, word index, rmask, wmask and wdata. Load counter=LATENCY-1, go to BUSY. If no port is pending, stay in IDLE.
  - BUSY: if counter!=0, decrement. If counter==0, go to RESP.
  - RESP: assert the granted port's resp for exactly this cycle, then return to IDLE.
  - The IDLE cycle after RESP may accept a new request.
- Latency: a request accepted at the edge ending cycle t has its resp high in cycle t+LATENCY+1 (1 idle-sample cycle + LATENCY). Throughput per port with no contention is one request per LATENCY+2 cycles.
- Arbitration:
  - If both ports are pending in IDLE, grant the port indicated by the pointer. The pointer then flips to the other port.
  - If only one port is pending, grant it and set the pointer to the other port.
  - The ungranted port simply stays pending. It is never dropped and is never starved past one transaction.
- Read: in the RESP cycle the granted port's rdata is loaded with the full 32-bit word at the latched index. All bytes are returned regardless of rmask; the requester selects bytes. rdata holds its value until that port's next resp. The other port's rdata is unchanged.
- Write (dmem only): in the RESP cycle, bytes whose latched wmask bit is set are written from latched wdata. wmask bit i maps to byte [8i+7:8i]. The write is visible to any request accepted afterwards.
- Read+write on the same dmem request: rdata returns the pre-write word and the write still occurs.
- Address: addr[1:0] is ignored. Misalignment is not checked.
- Preload: when load_en=1, load_data is written to load_addr that cycle. Preload works in any state, including during reset. If preload and a RESP write hit the same word in the same cycle, preload wins.
- Request changes mid-transaction: ignored, because all request fields are latched at acceptance.
- Reset mid-transaction: the transaction is abandoned with no resp and no write. State goes to IDLE the cycle after rst. The array is not cleared.

Test Plan:
- Preload word 0x10 = 0xDEADBEEF. imem reads addr 0x40, rmask 0xF, LATENCY=2 -> imem_resp is high exactly 3 cycles after the request first appears in IDLE, for 1 cycle, with imem_rdata=0xDEADBEEF. dmem_resp stays 0.
- dmem write addr 0x44, wdata 0x11223344, wmask 0x5, over preloaded 0xAABBCCDD -> then a dmem read of 0x44 returns 0xAA22CC44.
- imem (addr 0x0) and dmem (addr 0x4) both pending from reset -> imem is served first, then dmem. Next simultaneous pair -> dmem is served first (alternation). Neither resp overlaps the other.
- dmem rmask=0xF and wmask=0xF on a word holding 0x12345678, wdata 0xCAFEF00D -> dmem_rdata=0x12345678. A following read returns 0xCAFEF00D.
- Assert rst during BUSY of a dmem write of 0xFFFFFFFF to a word holding 0x0 -> no dmem_resp, and a later read returns 0x0. Both rdata outputs read 0 after reset.
- LATENCY=1, aliasing: preload index 0 = 0x5A5A5A5A, imem read of addr 0x1000 with DEPTH_LOG2=10 -> returns 0x5A5A5A5A with resp 2 cycles after the request.

Source files
------------

// File: rtl/ooo_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : ooo_mem_responder
// Description : Shared-array memory responder for the core's imem and dmem
//               request/response ports. Round-robin arbitration between the
//               ports, fixed LATENCY from acceptance to a one-cycle resp,
//               byte-masked dmem writes, and a bench preload port.
// Revision    : 1.0 - initial release
// ============================================================================
module ooo_mem_responder #(
    parameter int DEPTH_LOG2 = 10,
    parameter int LATENCY    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           imem_addr,
    input  logic [3:0]            imem_rmask,
    output logic [31:0]           imem_rdata,
    output logic                  imem_resp,
    input  logic [31:0]           dmem_addr,
    input  logic [3:0]            dmem_rmask,
    input  logic [3:0]            dmem_wmask,
    input  logic [31:0]           dmem_wdata,
    output logic [31:0]           dmem_rdata,
    output logic                  dmem_resp,
    input  logic                  load_en,
    input  logic [DEPTH_LOG2-1:0] load_addr,
    input  logic [31:0]           load_data
);

    localparam int          c_DEPTH    = 1 << DEPTH_LOG2;
    localparam logic [3:0]  c_CNT_INIT = 4'(LATENCY - 1);

    localparam logic [1:0]  c_ST_IDLE  = 2'd0;
    localparam logic [1:0]  c_ST_BUSY  = 2'd1;
    localparam logic [1:0]  c_ST_RESP  = 2'd2;

    logic [1:0]            r_state;
    logic [1:0]            w_state_next;
    logic [3:0]            r_cnt;
    logic                  r_port;      // 0 = imem, 1 = dmem
    logic                  r_ptr;       // 0 = imem wins next conflict
    logic [DEPTH_LOG2-1:0] r_idx;
    logic [3:0]            r_wmask;
    logic [31:0]           r_wdata;
    logic [31:0]           r_mem [c_DEPTH];

    logic                  w_imem_pend;
    logic                  w_dmem_pend;
    logic                  w_accept;
    logic                  w_grant_dmem;
    logic                  w_rdata_load;
    logic                  w_do_write;
    logic                  w_unused_addr;

    assign w_imem_pend  = (imem_rmask != 4'd0);
    assign w_dmem_pend  = ((dmem_rmask | dmem_wmask) != 4'd0);
    assign w_accept     = (r_state == c_ST_IDLE) && (w_imem_pend || w_dmem_pend);
    // dmem wins when it is alone, or when both pend and the pointer favours it
    assign w_grant_dmem = w_dmem_pend && (!w_imem_pend || r_ptr);
    // rdata is captured on the edge entering RESP so it is valid alongside resp,
    // and it therefore holds the pre-write word for a read+write request
    assign w_rdata_load = (r_state == c_ST_BUSY) && (r_cnt == 4'd0) && !rst;
    assign w_do_write   = (r_state == c_ST_RESP) && r_port && !rst;
    // Byte offset and high address bits are deliberately ignored (aliasing)
    assign w_unused_addr = &{1'b0, imem_addr, dmem_addr};

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_IDLE: if (w_imem_pend || w_dmem_pend) w_state_next = c_ST_BUSY;
            c_ST_BUSY: if (r_cnt == 4'd0)              w_state_next = c_ST_RESP;
            c_ST_RESP:                                 w_state_next = c_ST_IDLE;
            default:                                   w_state_next = c_ST_IDLE;
        endcase
    end

    // Response pulses: only the granted port, only in RESP, suppressed by reset
    always_comb begin
        imem_resp = (r_state == c_ST_RESP) && !r_port && !rst;
        dmem_resp = (r_state == c_ST_RESP) &&  r_port && !rst;
    end

    // Latch the granted request at acceptance and run the latency counter
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr   <= 1'b0;
            r_port  <= 1'b0;
            r_cnt   <= 4'd0;
            r_idx   <= '0;
            r_wmask <= 4'd0;
            r_wdata <= 32'd0;
        end else if (w_accept) begin
            r_port <= w_grant_dmem;
            r_ptr  <= !w_grant_dmem;
            r_cnt  <= c_CNT_INIT;
            if (w_grant_dmem) begin
                r_idx   <= dmem_addr[DEPTH_LOG2+1:2];
                r_wmask <= dmem_wmask;
                r_wdata <= dmem_wdata;
            end else begin
                r_idx   <= imem_addr[DEPTH_LOG2+1:2];
                r_wmask <= 4'd0;
                r_wdata <= 32'd0;
            end
        end else if ((r_state == c_ST_BUSY) && (r_cnt != 4'd0)) begin
            r_cnt <= r_cnt - 4'd1;
        end
    end

    // Read data registers; each holds until its own port's next response
    always_ff @(posedge clk) begin
        if (rst) begin
            imem_rdata <= 32'd0;
            dmem_rdata <= 32'd0;
        end else if (w_rdata_load) begin
            if (r_port) begin
                dmem_rdata <= r_mem[r_idx];
            end else begin
                imem_rdata <= r_mem[r_idx];
            end
        end
    end

    // Storage array: masked dmem write at the end of RESP, preload last so it wins
    always_ff @(posedge clk) begin
        if (w_do_write) begin
            for (int b = 0; b < 4; b++) begin
                if (r_wmask[b]) begin
                    r_mem[r_idx][8*b +: 8] <= r_wdata[8*b +: 8];
                end
            end
        end
        if (load_en) begin
            r_mem[load_addr] <= load_data;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ooo_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_ooo_mem_responder
// Description : Bench for ooo_mem_responder (LATENCY=2 main instance plus a
//               LATENCY=1 instance for the short-latency aliasing case).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ooo_mem_responder;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] imem_addr, dmem_addr, dmem_wdata, load_data;
    logic [3:0]  imem_rmask, dmem_rmask, dmem_wmask;
    logic        load_en;
    logic [9:0]  load_addr;
    logic [31:0] imem_rdata, dmem_rdata, imem_rdata_l1, dmem_rdata_l1;
    logic        imem_resp, dmem_resp, imem_resp_l1, dmem_resp_l1;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        bit          is_d;
        logic [31:0] addr;
        logic [3:0]  rmask;
        logic [3:0]  wmask;
        logic [31:0] wdata;
        bit          chk;
        logic [31:0] exp;
    } vec_t;

    typedef struct {
        bit          chk;
        logic [31:0] data;
    } exp_t;

    exp_t q_i[$];
    exp_t q_d[$];

    ooo_mem_responder #(.DEPTH_LOG2(10), .LATENCY(LAT)) dut (
        .clk(clk), .rst(rst),
        .imem_addr(imem_addr), .imem_rmask(imem_rmask),
        .imem_rdata(imem_rdata), .imem_resp(imem_resp),
        .dmem_addr(dmem_addr), .dmem_rmask(dmem_rmask), .dmem_wmask(dmem_wmask),
        .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp),
        .load_en(load_en), .load_addr(load_addr), .load_data(load_data)
    );

    ooo_mem_responder #(.DEPTH_LOG2(10), .LATENCY(1)) dut_l1 (
        .clk(clk), .rst(rst),
        .imem_addr(imem_addr), .imem_rmask(imem_rmask),
        .imem_rdata(imem_rdata_l1), .imem_resp(imem_resp_l1),
        .dmem_addr(dmem_addr), .dmem_rmask(dmem_rmask), .dmem_wmask(dmem_wmask),
        .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata_l1), .dmem_resp(dmem_resp_l1),
        .load_en(load_en), .load_addr(load_addr), .load_data(load_data)
    );

    always #5 clk = ~clk;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic note_fail(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s: got event, expected none", name);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_req;
        imem_addr  = 32'd0;
        imem_rmask = 4'd0;
        dmem_addr  = 32'd0;
        dmem_rmask = 4'd0;
        dmem_wmask = 4'd0;
        dmem_wdata = 32'd0;
    endtask

    task automatic preload(input logic [9:0] idx, input logic [31:0] data);
        load_en   = 1'b1;
        load_addr = idx;
        load_data = data;
        tick;
        load_en   = 1'b0;
    endtask

    // Issue one request from an IDLE cycle, wait for its resp, drop it after
    task automatic do_req(input vec_t v, output int lat);
        exp_t e;
        bit   seen;
        e.chk = v.chk;
        e.data = v.exp;
        seen = 1'b0;
        if (v.is_d) begin
            dmem_addr  = v.addr;
            dmem_rmask = v.rmask;
            dmem_wmask = v.wmask;
            dmem_wdata = v.wdata;
            q_d.push_back(e);
        end else begin
            imem_addr  = v.addr;
            imem_rmask = v.rmask;
            q_i.push_back(e);
        end
        lat = 0;
        for (int c = 0; c < 40 && !seen; c++) begin
            tick;
            lat++;
            if (v.is_d ? dmem_resp : imem_resp) seen = 1'b1;
        end
        if (!seen) lat = -1;
        tick;
        clear_req;
    endtask

    // Scoreboard monitor for the LATENCY=2 instance
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (imem_resp && dmem_resp) note_fail("resp_overlap");
        if (imem_resp) begin
            if (q_i.size() == 0) note_fail("imem_unexpected_resp");
            else begin
                e = q_i.pop_front();
                if (e.chk) check32("imem_rdata", imem_rdata, e.data);
            end
        end
        if (dmem_resp) begin
            if (q_d.size() == 0) note_fail("dmem_unexpected_resp");
            else begin
                e = q_d.pop_front();
                if (e.chk) check32("dmem_rdata", dmem_rdata, e.data);
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t vecs[8];
        int   lat;
        int   ti[2];
        int   td;
        int   ni;
        bit   dpend, drop_i, drop_d;
        int   resp_cnt;
        int   t1, t2;
        logic [31:0] rd2;

        //           is_d  addr          rmask  wmask  wdata          chk   exp
        vecs[0] = '{1'b0, 32'h0000_0040, 4'hF, 4'h0, 32'h0,         1'b1, 32'hDEADBEEF};
        vecs[1] = '{1'b1, 32'h0000_0044, 4'h0, 4'h5, 32'h11223344,  1'b0, 32'h0};
        vecs[2] = '{1'b1, 32'h0000_0044, 4'hF, 4'h0, 32'h0,         1'b1, 32'hAA22CC44};
        vecs[3] = '{1'b1, 32'h0000_0080, 4'hF, 4'hF, 32'hCAFEF00D,  1'b1, 32'h12345678};
        vecs[4] = '{1'b1, 32'h0000_0080, 4'hF, 4'h0, 32'h0,         1'b1, 32'hCAFEF00D};
        vecs[5] = '{1'b0, 32'h0000_0044, 4'hF, 4'h0, 32'h0,         1'b1, 32'hAA22CC44};
        vecs[6] = '{1'b1, 32'h0000_0048, 4'h0, 4'h8, 32'h77665544,  1'b0, 32'h0};
        vecs[7] = '{1'b0, 32'h0000_1041, 4'h1, 4'h0, 32'h0,         1'b1, 32'hDEADBEEF};

        rst = 1'b1;
        load_en = 1'b0;
        load_addr = '0;
        load_data = 32'd0;
        clear_req;

        // Preload while reset is held
        preload(10'h000, 32'h0A0A0A0A);
        preload(10'h001, 32'h01010101);
        preload(10'h002, 32'h02020202);
        preload(10'h010, 32'hDEADBEEF);
        preload(10'h011, 32'hAABBCCDD);
        preload(10'h012, 32'h00000000);
        preload(10'h020, 32'h12345678);
        preload(10'h030, 32'h00000000);
        rst = 1'b0;

        check32("reset_imem_rdata", imem_rdata, 32'h0);
        check32("reset_dmem_rdata", dmem_rdata, 32'h0);
        check32("reset_imem_resp", {31'd0, imem_resp}, 32'h0);
        check32("reset_dmem_resp", {31'd0, dmem_resp}, 32'h0);

        // Arbitration: both pend from reset; imem re-requests right after its resp
        imem_addr = 32'h0; imem_rmask = 4'hF;
        dmem_addr = 32'h4; dmem_rmask = 4'hF;
        q_i.push_back('{1'b1, 32'h0A0A0A0A});
        q_i.push_back('{1'b1, 32'h02020202});
        q_d.push_back('{1'b1, 32'h01010101});
        ti[0] = 0; ti[1] = 0; td = 0; ni = 0;
        dpend = 1'b1; drop_i = 1'b0; drop_d = 1'b0;
        for (int c = 1; c <= 40 && (ni < 2 || dpend); c++) begin
            tick;
            if (drop_i) begin
                if (ni == 1) imem_addr = 32'h8;
                else         imem_rmask = 4'h0;
                drop_i = 1'b0;
            end
            if (drop_d) begin
                dmem_rmask = 4'h0;
                drop_d = 1'b0;
            end
            if (imem_resp && ni < 2) begin ti[ni] = c; ni++; drop_i = 1'b1; end
            if (dmem_resp) begin td = c; dpend = 1'b0; drop_d = 1'b1; end
        end
        tick;
        clear_req;
        check32("arb_imem_first_cycle", 32'(ti[0]), 32'(LAT + 1));
        check32("arb_dmem_second_cycle", 32'(td), 32'(2 * (LAT + 2) - 1));
        check32("arb_imem_third_cycle", 32'(ti[1]), 32'(3 * (LAT + 2) - 1));

        // Table-driven single transactions
        for (int i = 0; i < 8; i++) begin
            do_req(vecs[i], lat);
            check32($sformatf("vec%0d_latency", i), 32'(lat), 32'(LAT + 1));
        end
        // Full word returned for a one-byte read after a top-byte write
        begin
            vec_t v;
            v = '{1'b1, 32'h0000_0048, 4'h1, 4'h0, 32'h0, 1'b1, 32'h77000000};
            do_req(v, lat);
            check32("byte_write_latency", 32'(lat), 32'(LAT + 1));
        end

        // Reset during BUSY abandons a full-word write
        dmem_addr = 32'hC0; dmem_wmask = 4'hF; dmem_wdata = 32'hFFFFFFFF;
        tick;
        rst = 1'b1;
        clear_req;
        tick;
        rst = 1'b0;
        check32("midrst_imem_rdata", imem_rdata, 32'h0);
        check32("midrst_dmem_rdata", dmem_rdata, 32'h0);
        resp_cnt = 0;
        for (int c = 0; c < 6; c++) begin
            tick;
            if (dmem_resp) resp_cnt++;
        end
        check32("midrst_no_resp", 32'(resp_cnt), 32'h0);
        begin
            vec_t v;
            v = '{1'b1, 32'h0000_00C0, 4'hF, 4'h0, 32'h0, 1'b1, 32'h00000000};
            do_req(v, lat);
            check32("midrst_readback_latency", 32'(lat), 32'(LAT + 1));
        end

        // LATENCY=1 instance with aliasing address
        rst = 1'b1;
        preload(10'h000, 32'h5A5A5A5A);
        rst = 1'b0;
        imem_addr = 32'h1000; imem_rmask = 4'hF;
        q_i.push_back('{1'b1, 32'h5A5A5A5A});
        t1 = 0; t2 = 0; rd2 = 32'd0;
        for (int c = 1; c <= 20 && (t1 == 0 || t2 == 0); c++) begin
            tick;
            if (imem_resp_l1 && t2 == 0) begin t2 = c; rd2 = imem_rdata_l1; end
            if (imem_resp && t1 == 0) t1 = c;
        end
        tick;
        clear_req;
        check32("l1_latency", 32'(t2), 32'd2);
        check32("l1_alias_rdata", rd2, 32'h5A5A5A5A);
        check32("l2_alias_latency", 32'(t1), 32'(LAT + 1));
        repeat (4) tick;

        check32("imem_queue_empty", 32'(q_i.size()), 32'h0);
        check32("dmem_queue_empty", 32'(q_d.size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
